dmem_responder: RTL and testbench

// Memory-side responder for the core's data port: accepts load/store requests
// (address = alu_result, data = write_data) over a valid/ready handshake and returns

---
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request port, word array backing store,
// fixed wait-state latency and a held response until the core accepts it.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WC = 4'(WAIT_CYCLES);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          acc_err;
  logic          mem_we;
  logic [31:0]   word_idx;
  logic [AW-1:0] mem_idx;

  assign req_ready  = (state_q == S_IDLE) && reset;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign accept   = req_valid && req_ready;
  assign word_idx = {2'b00, addr_q[31:2]};
  assign mem_idx  = addr_q[AW+1:2];
  // Full 30-bit index compare so high addresses never alias.
  assign acc_err  = (addr_q[1:0] != 2'b00) ||
                    (word_idx >= DEPTH_L);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = WC;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          err_d   = acc_err;
          mem_we  = wr_q && !acc_err;
          if (acc_err || wr_q)
            rdata_d = '0;
          else
            rdata_d = mem_q[mem_idx];
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Array is not reset; a reset edge suppresses the pending write.
  always_ff @(posedge clk) begin
    if (mem_we && reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i])
          mem_q[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states)
// sharing request fields, checked against a queue of expected responses.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_ready;

  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  dmem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(2)
  ) u_a (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid && !sel),
    .req_ready  (a_req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (a_resp_valid),
    .resp_ready (resp_ready && !sel),
    .resp_rdata (a_resp_rdata),
    .resp_err   (a_resp_err)
  );

  dmem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(0)
  ) u_b (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid && sel),
    .req_ready  (b_req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (b_resp_valid),
    .resp_ready (resp_ready && sel),
    .resp_rdata (b_resp_rdata),
    .resp_err   (b_resp_err)
  );

  logic        cur_req_ready, cur_resp_valid, cur_resp_err;
  logic [31:0] cur_resp_rdata;
  assign cur_req_ready  = sel ? b_req_ready  : a_req_ready;
  assign cur_resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign cur_resp_err   = sel ? b_resp_err   : a_resp_err;
  assign cur_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][256];
  logic [31:0] last_rdata;
  int          checks = 0;
  int          errors = 0;

  task automatic start_req(input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be,
                           input bit push, output bit ok);
    int   n;
    int   s;
    exp_t e;
    logic bad;
    logic [31:0] w;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    n = 0;
    while (!cur_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cur_req_ready) begin
      errors++;
      $display("FAIL accept_timeout addr=%h ready=%b want 1",
               a, cur_req_ready);
      req_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    ok = 1'b1;
    if (push) begin
      s   = sel ? 1 : 0;
      bad = (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'd256);
      e.err   = bad;
      e.rdata = '0;
      if (!bad) begin
        if (wr) begin
          w = model[s][a[9:2]];
          for (int i = 0; i < 4; i++)
            if (be[i]) w[8*i +: 8] = d[8*i +: 8];
          model[s][a[9:2]] = w;
        end else begin
          e.rdata = model[s][a[9:2]];
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_resp(input string tag, input int hold);
    int   lat;
    int   want;
    exp_t e;
    lat  = 0;
    want = sel ? 1 : 3;
    while (!cur_resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (!cur_resp_valid) begin
      errors++;
      $display("FAIL %s resp_timeout valid=%b want 1", tag, cur_resp_valid);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (lat != want) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", tag, lat, want);
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s sb_empty got 1 want 0", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (cur_resp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s rdata got %h want %h", tag, cur_resp_rdata, e.rdata);
    end
    checks++;
    if (cur_resp_err !== e.err) begin
      errors++;
      $display("FAIL %s err got %b want %b", tag, cur_resp_err, e.err);
    end
    last_rdata = cur_resp_rdata;
    if (hold > 0) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_0020;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        checks++;
        if (cur_resp_valid !== 1'b1 || cur_resp_rdata !== e.rdata ||
            cur_req_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s hold%0d v=%b d=%h rdy=%b want 1 %h 0",
                   tag, i, cur_resp_valid, cur_resp_rdata,
                   cur_req_ready, e.rdata);
        end
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checks++;
    if (cur_resp_valid !== 1'b0 || cur_resp_rdata !== 32'h0 ||
        cur_resp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s release v=%b d=%h e=%b want 0 0 0",
               tag, cur_resp_valid, cur_resp_rdata, cur_resp_err);
    end
    if (hold > 0) begin
      checks++;
      if (cur_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s early_accept ready=%b want 1", tag, cur_req_ready);
      end
      req_valid = 1'b0;
    end
  endtask

  task automatic send(input string tag, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int hold);
    bit ok;
    start_req(wr, a, d, be, 1'b1, ok);
    if (ok) wait_resp(tag, hold);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_req_ready !== 1'b0 || a_resp_valid !== 1'b0 ||
          a_resp_rdata !== 32'h0 || a_resp_err !== 1'b0 ||
          b_req_ready !== 1'b0 || b_resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_%0d rdy=%b v=%b d=%h e=%b want 0 0 0 0",
                 i, a_req_ready, a_resp_valid, a_resp_rdata, a_resp_err);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release rdy=%b/%b want 1/1",
               a_req_ready, b_req_ready);
    end
  endtask

  task automatic test_store_load();
    send("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    send("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0);
    checks++;
    if (last_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ld10_const got %h want deadbeef", last_rdata);
    end
  endtask

  task automatic test_byte_enables();
    send("st20a", 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    send("st20b", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    send("st20c", 1'b1, 32'h20, 32'h99999999, 4'b0000, 0);
    send("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 0);
    checks++;
    if (last_rdata !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL ld20_const got %h want 11bb33dd", last_rdata);
    end
  endtask

  task automatic test_errors();
    send("st0", 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 0);
    send("ld13", 1'b0, 32'h13, 32'h0, 4'h0, 0);
    send("st400", 1'b1, 32'h400, 32'h12121212, 4'hF, 0);
    send("sthigh", 1'b1, 32'h8000_0000, 32'h34343434, 4'hF, 0);
    send("ld0", 1'b0, 32'h0, 32'h0, 4'h0, 0);
    checks++;
    if (last_rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL ld0_const got %h want a5a5a5a5", last_rdata);
    end
    send("ld3fc", 1'b0, 32'h3FC, 32'h0, 4'h0, 0);
  endtask

  task automatic test_backpressure();
    send("bp_ld10", 1'b0, 32'h10, 32'h0, 4'h0, 5);
  endtask

  task automatic test_reset_midop();
    bit ok;
    send("pre8", 1'b1, 32'h8, 32'h12345678, 4'hF, 0);
    start_req(1'b1, 32'h8, 32'h55, 4'hF, 1'b0, ok);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset v=%b rdy=%b want 0 0",
               a_resp_valid, a_req_ready);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (a_resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL midop_stale%0d v=%b want 0", i, a_resp_valid);
      end
    end
    send("ld8", 1'b0, 32'h8, 32'h0, 4'h0, 0);
    checks++;
    if (last_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL ld8_const got %h want 12345678", last_rdata);
    end
    start_req(1'b1, 32'hC, 32'hCAFEF00D, 4'hF, 1'b1, ok);
    void'(sb.pop_front());
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_reset_pre v=%b want 1", a_resp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (a_resp_valid !== 1'b0 || a_resp_err !== 1'b0) begin
      errors++;
      $display("FAIL resp_reset_drop v=%b e=%b want 0 0",
               a_resp_valid, a_resp_err);
    end
    @(negedge clk);
    reset = 1'b1;
    send("ldC", 1'b0, 32'hC, 32'h0, 4'h0, 0);
  endtask

  task automatic test_zero_wait();
    @(negedge clk);
    sel = 1'b1;
    send("z_st40", 1'b1, 32'h40, 32'h0BADF00D, 4'hF, 0);
    send("z_ld40", 1'b0, 32'h40, 32'h0, 4'h0, 0);
    send("z_st400", 1'b1, 32'h400, 32'h1, 4'hF, 0);
    send("z_ld41", 1'b0, 32'h41, 32'h0, 4'h0, 0);
    send("z_bp", 1'b0, 32'h40, 32'h0, 4'h0, 2);
    @(negedge clk);
    sel = 1'b0;
  endtask

  initial begin
    sel        = 1'b0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b0;
    last_rdata = '0;
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_backpressure();
    test_reset_midop();
    test_zero_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t want <200000", $time);
    $fatal(1);
  end

endmodule
